// File: rtl/cci_test_req_arb.sv
// N-client read-request arbiter: tags mdata with a client ID, round-robins under almost-full,
// caps per-client outstanding reads and routes responses back by tag. Option: CCI_TEST_ARB_STATS_EN.
module cci_test_req_arb #(
    parameter int NUM_CLIENTS     = 4,
    parameter int ADDR_W          = 42,
    parameter int CLIENT_MDATA_W  = 12,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 64,
    localparam int ID_W           = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1,
    localparam int MDATA_W        = CLIENT_MDATA_W + ID_W,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CLIENTS-1:0]               req_valid,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]        req_addr,
    input  logic [NUM_CLIENTS*CLIENT_MDATA_W-1:0] req_mdata,
    output logic [NUM_CLIENTS-1:0]               req_ready,
    input  logic                                 tx_almost_full,
    output logic                                 tx_valid,
    output logic [ADDR_W-1:0]                    tx_addr,
    output logic [MDATA_W-1:0]                   tx_mdata,
    input  logic                                 rx_valid,
    input  logic [MDATA_W-1:0]                   rx_mdata,
    input  logic [DATA_W-1:0]                    rx_data,
    output logic [NUM_CLIENTS-1:0]               rsp_valid,
    output logic [CLIENT_MDATA_W-1:0]            rsp_mdata,
    output logic [DATA_W-1:0]                    rsp_data,
    output logic [NUM_CLIENTS*CNT_W-1:0]         outstanding,
    output logic                                 err_rsp
`ifdef CCI_TEST_ARB_STATS_EN
    ,
    input  logic [ID_W-1:0]                      stat_sel,
    output logic [31:0]                          stat_grants,
    output logic [31:0]                          stat_stalls
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT       = CNT_W'(MAX_OUTSTANDING);
    localparam logic [ID_W:0]    NUM_CLIENTS_W = (ID_W + 1)'(NUM_CLIENTS);
    localparam logic [ID_W-1:0]  LAST_ID       = ID_W'(NUM_CLIENTS - 1);

    logic [NUM_CLIENTS-1:0] eligible;
    logic [NUM_CLIENTS-1:0] grant;
    logic                   grant_any;
    logic [ID_W-1:0]        grant_id;
    logic [ID_W-1:0]        rr_ptr_q;

    logic [ADDR_W-1:0]         sel_addr;
    logic [CLIENT_MDATA_W-1:0] sel_mdata;

    logic [ID_W-1:0]        rx_id;
    logic                   rx_id_ok;
    logic [NUM_CLIENTS-1:0] rsp_hit;
    logic [NUM_CLIENTS-1:0] rsp_zero;

    logic                      tx_valid_q;
    logic [ADDR_W-1:0]         tx_addr_q;
    logic [MDATA_W-1:0]        tx_mdata_q;
    logic [NUM_CLIENTS-1:0]    rsp_valid_q;
    logic [CLIENT_MDATA_W-1:0] rsp_mdata_q;
    logic [DATA_W-1:0]         rsp_data_q;
    logic                      err_q;
    logic                      err_d;

    // Round-robin scan starting just after the last granted client.
    always_comb begin
        int              scan_idx;
        logic [ID_W-1:0] cand;
        scan_idx  = 0;
        cand      = '0;
        grant     = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        if (!reset && !tx_almost_full) begin
            for (int k = 1; k <= NUM_CLIENTS; k++) begin
                scan_idx = int'(rr_ptr_q) + k;
                if (scan_idx >= NUM_CLIENTS) begin
                    scan_idx = scan_idx - NUM_CLIENTS;
                end
                cand = ID_W'(scan_idx);
                if (!grant_any && eligible[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
            if (grant_any) begin
                grant[grant_id] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_mdata = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_mdata = req_mdata[i*CLIENT_MDATA_W +: CLIENT_MDATA_W];
            end
        end
    end

    assign rx_id    = rx_mdata[MDATA_W-1 -: ID_W];
    assign rx_id_ok = ({1'b0, rx_id} < NUM_CLIENTS_W);

    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            rsp_hit[i] = rx_valid && rx_id_ok && (rx_id == ID_W'(i));
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : gen_client
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;

            // A grant and a response for the same client cancel; a response never drops below 0.
            always_comb begin
                cnt_d = cnt_q;
                if (grant[gi] && !rsp_hit[gi]) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (!grant[gi] && rsp_hit[gi] && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign eligible[gi]                     = req_valid[gi] && (cnt_q < MAX_CNT);
            assign rsp_zero[gi]                     = rsp_hit[gi] && (cnt_q == '0);
            assign outstanding[gi*CNT_W +: CNT_W]   = cnt_q;
        end
    endgenerate

    assign err_d = err_q | (rx_valid && !rx_id_ok) | (|rsp_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            err_q       <= 1'b0;
            rr_ptr_q    <= LAST_ID;
        end else begin
            tx_valid_q  <= grant_any;
            rsp_valid_q <= rsp_hit;
            err_q       <= err_d;
            if (grant_any) begin
                rr_ptr_q <= grant_id;
            end
        end
    end

    // Payload registers carry no reset; qualified by the valid flags above.
    always_ff @(posedge clk) begin
        tx_addr_q   <= sel_addr;
        tx_mdata_q  <= {grant_id, sel_mdata};
        rsp_mdata_q <= rx_mdata[CLIENT_MDATA_W-1:0];
        rsp_data_q  <= rx_data;
    end

    assign req_ready = grant;
    assign tx_valid  = tx_valid_q;
    assign tx_addr   = tx_addr_q;
    assign tx_mdata  = tx_mdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_mdata = rsp_mdata_q;
    assign rsp_data  = rsp_data_q;
    assign err_rsp   = err_q;

`ifdef CCI_TEST_ARB_STATS_EN
    logic [NUM_CLIENTS-1:0][31:0] grant_cnt_all;
    logic [NUM_CLIENTS-1:0][31:0] stall_cnt_all;
    logic [31:0]                  stat_grants_q;
    logic [31:0]                  stat_stalls_q;

    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : gen_stats
            logic [31:0] grant_cnt_q;
            logic [31:0] stall_cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    grant_cnt_q <= '0;
                    stall_cnt_q <= '0;
                end else begin
                    if (grant[gi]) begin
                        grant_cnt_q <= grant_cnt_q + 32'd1;
                    end
                    if (req_valid[gi] && tx_almost_full) begin
                        stall_cnt_q <= stall_cnt_q + 32'd1;
                    end
                end
            end

            assign grant_cnt_all[gi] = grant_cnt_q;
            assign stall_cnt_all[gi] = stall_cnt_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else if ({1'b0, stat_sel} < NUM_CLIENTS_W) begin
            stat_grants_q <= grant_cnt_all[stat_sel];
            stat_stalls_q <= stall_cnt_all[stat_sel];
        end else begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_cci_test_req_arb.sv
// Self-checking bench for cci_test_req_arb: directed scenarios plus randomized traffic
// against a queue-free behavioural model of the arbitration and counting rules.
module tb_cci_test_req_arb;

    localparam int N    = 4;
    localparam int AW   = 42;
    localparam int CMW  = 12;
    localparam int DW   = 512;
    localparam int MAXO = 64;
    localparam int IDW  = 2;
    localparam int MW   = CMW + IDW;
    localparam int CW   = 7;

    localparam int N3  = 3;
    localparam int DW3 = 32;
    localparam int CW3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*CMW-1:0]  req_mdata;
    logic [N-1:0]      req_ready;
    logic              tx_almost_full;
    logic              tx_valid;
    logic [AW-1:0]     tx_addr;
    logic [MW-1:0]     tx_mdata;
    logic              rx_valid;
    logic [MW-1:0]     rx_mdata;
    logic [DW-1:0]     rx_data;
    logic [N-1:0]      rsp_valid;
    logic [CMW-1:0]    rsp_mdata;
    logic [DW-1:0]     rsp_data;
    logic [N*CW-1:0]   outstanding;
    logic              err_rsp;

    logic              reset3;
    logic [N3-1:0]     req_valid3;
    logic [N3*AW-1:0]  req_addr3;
    logic [N3*CMW-1:0] req_mdata3;
    logic [N3-1:0]     req_ready3;
    logic              tx_valid3;
    logic [AW-1:0]     tx_addr3;
    logic [MW-1:0]     tx_mdata3;
    logic              rx_valid3;
    logic [MW-1:0]     rx_mdata3;
    logic [DW3-1:0]    rx_data3;
    logic [N3-1:0]     rsp_valid3;
    logic [CMW-1:0]    rsp_mdata3;
    logic [DW3-1:0]    rsp_data3;
    logic [N3*CW3-1:0] outstanding3;
    logic              err_rsp3;

`ifdef CCI_TEST_ARB_STATS_EN
    logic [IDW-1:0] stat_sel;
    logic [31:0]    stat_grants, stat_stalls;
    logic [IDW-1:0] stat_sel3;
    logic [31:0]    stat_grants3, stat_stalls3;
    assign stat_sel  = '0;
    assign stat_sel3 = '0;
`endif

    cci_test_req_arb #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .CLIENT_MDATA_W(CMW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_mdata(req_mdata), .req_ready(req_ready),
        .tx_almost_full(tx_almost_full),
        .tx_valid(tx_valid), .tx_addr(tx_addr), .tx_mdata(tx_mdata),
        .rx_valid(rx_valid), .rx_mdata(rx_mdata), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
        .outstanding(outstanding), .err_rsp(err_rsp)
`ifdef CCI_TEST_ARB_STATS_EN
        , .stat_sel(stat_sel), .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    cci_test_req_arb #(
        .NUM_CLIENTS(N3), .ADDR_W(AW), .CLIENT_MDATA_W(CMW), .DATA_W(DW3), .MAX_OUTSTANDING(4)
    ) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid(req_valid3), .req_addr(req_addr3), .req_mdata(req_mdata3), .req_ready(req_ready3),
        .tx_almost_full(1'b0),
        .tx_valid(tx_valid3), .tx_addr(tx_addr3), .tx_mdata(tx_mdata3),
        .rx_valid(rx_valid3), .rx_mdata(rx_mdata3), .rx_data(rx_data3),
        .rsp_valid(rsp_valid3), .rsp_mdata(rsp_mdata3), .rsp_data(rsp_data3),
        .outstanding(outstanding3), .err_rsp(err_rsp3)
`ifdef CCI_TEST_ARB_STATS_EN
        , .stat_sel(stat_sel3), .stat_grants(stat_grants3), .stat_stalls(stat_stalls3)
`endif
    );

    // Reference model state: counts per client, last granted client, expected registered outputs.
    int            cnt [N];
    int            last;
    bit            m_err;
    bit            e_tx_valid;
    logic [AW-1:0] e_tx_addr;
    logic [MW-1:0] e_tx_mdata;
    logic [N-1:0]  e_rsp_valid;
    logic [CMW-1:0] e_rsp_mdata;
    logic [DW-1:0] e_rsp_data;

    int n_vec = 0;
    int n_err = 0;

    function automatic int pred_grant();
        int c;
        if (reset || tx_almost_full) return -1;
        for (int k = 1; k <= N; k++) begin
            c = (last + k) % N;
            if (req_valid[c] && cnt[c] < MAXO) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] pred_ready();
        int g;
        logic [N-1:0] r;
        g = pred_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [N*CW-1:0] pack_cnt();
        logic [N*CW-1:0] p;
        for (int i = 0; i < N; i++) p[i*CW +: CW] = CW'(cnt[i]);
        return p;
    endfunction

    // Advance one clock and apply the behavioural rules to the model.
    task automatic tick();
        int g;
        int id;
        g = pred_grant();
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < N; i++) cnt[i] = 0;
            last        = N - 1;
            m_err       = 1'b0;
            e_tx_valid  = 1'b0;
            e_rsp_valid = '0;
        end else begin
            e_tx_valid = (g >= 0);
            if (g >= 0) begin
                e_tx_addr  = req_addr[g*AW +: AW];
                e_tx_mdata = {IDW'(g), req_mdata[g*CMW +: CMW]};
                last       = g;
            end
            e_rsp_valid = '0;
            id = -1;
            if (rx_valid) begin
                id = int'(rx_mdata[MW-1 -: IDW]);
                e_rsp_valid[id] = 1'b1;
                e_rsp_mdata     = rx_mdata[CMW-1:0];
                e_rsp_data      = rx_data;
                if (cnt[id] == 0) m_err = 1'b1;
            end
            if (!(g >= 0 && id == g)) begin
                if (g >= 0) cnt[g] = cnt[g] + 1;
                if (id >= 0 && cnt[id] > 0) cnt[id] = cnt[id] - 1;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; rx_valid = 1'b0; tx_almost_full = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '1; tx_almost_full = 1'b0; rx_valid = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
        tick();
        tick();
        n_vec++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        n_vec++;
        if (rsp_valid !== '0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_vec++;
        if (outstanding !== '0) begin n_err++; $display("FAIL reset_outstanding: got %h expected 0", outstanding); end
        n_vec++;
        if (err_rsp !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b expected 0", err_rsp); end
        reset = 1'b0; req_valid = '0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_r;
        do_reset();
        req_valid = '1;
        for (int c = 0; c < 262; c++) begin
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]    = AW'({$urandom(), $urandom()});
                req_mdata[i*CMW +: CMW] = CMW'($urandom());
            end
            #1;
            exp_r = (c < 256) ? (N'(1) << (c % N)) : '0;
            n_vec++;
            if (req_ready !== exp_r) begin
                n_err++; $display("FAIL rr_ready[%0d]: got %b expected %b", c, req_ready, exp_r);
            end
            tick();
            n_vec++;
            if (tx_valid !== (c < 256)) begin
                n_err++; $display("FAIL rr_tx_valid[%0d]: got %b expected %b", c, tx_valid, (c < 256));
            end else if (c < 256) begin
                n_vec++;
                if (tx_mdata[MW-1 -: IDW] !== IDW'(c % N) || tx_mdata !== e_tx_mdata) begin
                    n_err++; $display("FAIL rr_tx_mdata[%0d]: got %h expected %h", c, tx_mdata, e_tx_mdata);
                end
            end
        end
        n_vec++;
        if (outstanding !== {N{7'd64}}) begin
            n_err++; $display("FAIL rr_saturated: got %h expected %h", outstanding, {N{7'd64}});
        end
        req_valid = '0;
    endtask

    task automatic test_single_client();
        do_reset();
        req_addr  = {N*AW{1'b1}};
        req_mdata = {N*CMW{1'b1}};
        req_addr[2*AW +: AW]    = 42'h1000;
        req_mdata[2*CMW +: CMW] = 12'hABC;
        req_valid = 4'b0100;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
        n_vec++;
        if (tx_valid !== 1'b1) begin n_err++; $display("FAIL single_tx_valid: got %b expected 1", tx_valid); end
        n_vec++;
        if (tx_addr !== 42'h1000) begin n_err++; $display("FAIL single_tx_addr: got %h expected 1000", tx_addr); end
        n_vec++;
        if (tx_mdata !== 14'h2ABC) begin n_err++; $display("FAIL single_tx_mdata: got %h expected 2abc", tx_mdata); end
        tick();
        n_vec++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL single_tx_idle: got %b expected 0", tx_valid); end
    endtask

    task automatic test_almost_full();
        do_reset();
        req_valid = '1;
        tick();
        tick();
        tx_almost_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_vec++;
            if (req_ready !== '0) begin n_err++; $display("FAIL af_ready[%0d]: got %b expected 0", k, req_ready); end
            tick();
            n_vec++;
            if (tx_valid !== 1'b0) begin n_err++; $display("FAIL af_tx_valid[%0d]: got %b expected 0", k, tx_valid); end
        end
        tx_almost_full = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 4'b0100) begin n_err++; $display("FAIL af_resume: got %b expected 0100", req_ready); end
        tick();
        req_valid = '0;
    endtask

    task automatic test_same_cycle();
        logic [DW-1:0] d;
        do_reset();
        req_valid = 4'b0010;
        tick(); tick(); tick();
        n_vec++;
        if (outstanding[CW +: CW] !== 7'd3) begin n_err++; $display("FAIL same_pre: got %0d expected 3", outstanding[CW +: CW]); end
        for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom();
        rx_valid = 1'b1; rx_mdata = 14'h1055; rx_data = d;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin n_err++; $display("FAIL same_ready: got %b expected 0010", req_ready); end
        tick();
        rx_valid = 1'b0; req_valid = '0;
        n_vec++;
        if (rsp_valid !== 4'b0010) begin n_err++; $display("FAIL same_rsp_valid: got %b expected 0010", rsp_valid); end
        n_vec++;
        if (rsp_mdata !== 12'h055) begin n_err++; $display("FAIL same_rsp_mdata: got %h expected 055", rsp_mdata); end
        n_vec++;
        if (rsp_data !== d) begin n_err++; $display("FAIL same_rsp_data: got %h expected %h", rsp_data[63:0], d[63:0]); end
        n_vec++;
        if (outstanding[CW +: CW] !== 7'd3) begin n_err++; $display("FAIL same_cnt: got %0d expected 3", outstanding[CW +: CW]); end
        n_vec++;
        if (err_rsp !== 1'b0) begin n_err++; $display("FAIL same_err: got %b expected 0", err_rsp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) tick();
        n_vec++;
        if (outstanding[0 +: CW] !== 7'd5) begin n_err++; $display("FAIL mid_pre: got %0d expected 5", outstanding[0 +: CW]); end
        reset = 1'b1;
        #1;
        n_vec++;
        if (req_ready !== '0) begin n_err++; $display("FAIL mid_ready: got %b expected 0", req_ready); end
        tick();
        reset = 1'b0; req_valid = '0;
        n_vec++;
        if (outstanding !== '0) begin n_err++; $display("FAIL mid_outstanding: got %h expected 0", outstanding); end
        n_vec++;
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid: got %b expected 0", tx_valid); end
        tick();
        n_vec++;
        if (err_rsp !== 1'b0) begin n_err++; $display("FAIL mid_err_pre: got %b expected 0", err_rsp); end
        rx_valid = 1'b1; rx_mdata = 14'h0123;
        tick();
        rx_valid = 1'b0;
        n_vec++;
        if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL mid_rsp_valid: got %b expected 0001", rsp_valid); end
        n_vec++;
        if (rsp_mdata !== 12'h123) begin n_err++; $display("FAIL mid_rsp_mdata: got %h expected 123", rsp_mdata); end
        n_vec++;
        if (err_rsp !== 1'b1) begin n_err++; $display("FAIL mid_err: got %b expected 1", err_rsp); end
        n_vec++;
        if (outstanding !== '0) begin n_err++; $display("FAIL mid_cnt_zero: got %h expected 0", outstanding); end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_r;
        int busy [$];
        int id;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid      = N'($urandom_range(0, 15));
            tx_almost_full = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]    = AW'({$urandom(), $urandom()});
                req_mdata[i*CMW +: CMW] = CMW'($urandom());
            end
            rx_valid = ($urandom_range(0, 1) == 1);
            busy.delete();
            for (int i = 0; i < N; i++) if (cnt[i] > 0) busy.push_back(i);
            if (busy.size() > 0 && $urandom_range(0, 7) != 0) id = busy[$urandom_range(0, busy.size() - 1)];
            else id = $urandom_range(0, N - 1);
            rx_mdata = {IDW'(id), CMW'($urandom())};
            for (int j = 0; j < DW / 32; j++) rx_data[j*32 +: 32] = $urandom();
            #1;
            exp_r = pred_ready();
            n_vec++;
            if (req_ready !== exp_r) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, req_ready, exp_r); end
            tick();
            n_vec++;
            if (tx_valid !== e_tx_valid) begin
                n_err++; $display("FAIL rnd_tx_valid[%0d]: got %b expected %b", c, tx_valid, e_tx_valid);
            end else if (e_tx_valid) begin
                n_vec++;
                if (tx_addr !== e_tx_addr || tx_mdata !== e_tx_mdata) begin
                    n_err++; $display("FAIL rnd_tx[%0d]: got %h/%h expected %h/%h", c, tx_addr, tx_mdata, e_tx_addr, e_tx_mdata);
                end
            end
            n_vec++;
            if (rsp_valid !== e_rsp_valid) begin
                n_err++; $display("FAIL rnd_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, e_rsp_valid);
            end else if (e_rsp_valid != '0) begin
                n_vec++;
                if (rsp_mdata !== e_rsp_mdata || rsp_data !== e_rsp_data) begin
                    n_err++; $display("FAIL rnd_rsp[%0d]: got %h/%h expected %h/%h", c, rsp_mdata, rsp_data[63:0], e_rsp_mdata, e_rsp_data[63:0]);
                end
            end
            n_vec++;
            if (outstanding !== pack_cnt()) begin
                n_err++; $display("FAIL rnd_outstanding[%0d]: got %h expected %h", c, outstanding, pack_cnt());
            end
            n_vec++;
            if (err_rsp !== m_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, err_rsp, m_err); end
        end
        req_valid = '0; rx_valid = 1'b0; tx_almost_full = 1'b0;
    endtask

    task automatic test_bad_id();
        reset3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        n_vec++;
        if (err_rsp3 !== 1'b0) begin n_err++; $display("FAIL badid_err_pre: got %b expected 0", err_rsp3); end
        rx_valid3 = 1'b1; rx_mdata3 = 14'h3055;
        @(posedge clk); #1;
        rx_valid3 = 1'b0;
        n_vec++;
        if (rsp_valid3 !== '0) begin n_err++; $display("FAIL badid_rsp_valid: got %b expected 0", rsp_valid3); end
        n_vec++;
        if (err_rsp3 !== 1'b1) begin n_err++; $display("FAIL badid_err: got %b expected 1", err_rsp3); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_vec++;
            if (err_rsp3 !== 1'b1) begin n_err++; $display("FAIL badid_sticky[%0d]: got %b expected 1", k, err_rsp3); end
        end
        reset3 = 1'b1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        n_vec++;
        if (err_rsp3 !== 1'b0) begin n_err++; $display("FAIL badid_err_clear: got %b expected 0", err_rsp3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req_valid = '0; req_addr = '0; req_mdata = '0;
        tx_almost_full = 1'b0; rx_valid = 1'b0; rx_mdata = '0; rx_data = '0;
        reset3 = 1'b1; req_valid3 = '0; req_addr3 = '0; req_mdata3 = '0;
        rx_valid3 = 1'b0; rx_mdata3 = '0; rx_data3 = '0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        last = N - 1; m_err = 1'b0; e_tx_valid = 1'b0; e_rsp_valid = '0;
        e_tx_addr = '0; e_tx_mdata = '0; e_rsp_mdata = '0; e_rsp_data = '0;
        @(posedge clk); #1;
        test_reset();
        test_round_robin();
        test_single_client();
        test_almost_full();
        test_same_cycle();
        test_reset_mid();
        test_random();
        test_bad_id();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
